mips_mem_bus_arbiter: RTL and testbench
=======================================

// Module: mips_mem_bus_arbiter
// PURPOSE
//  Shares the single data memory bus between two requesters: port 0 = core load/store unit, port 1 = program loader / debug master.
//  Serialises one transaction at a time and drives mem_bus_read/write and the rd/wr addresses into the memory-map decoder.
//  Waits a fixed read latency, then returns the data or the decoder's address error to the owning requester.
// PARAMETERS
//  DATA_W        32  data bus width (DATA_32_W)
//  ADDR_W        32  bus address width (ADDRESS_32_W)
//  RD_LATENCY    1   cycles from the ISSUE cycle to valid mem_bus_rd_data; legal range 1..7
//  STARVE_LIMIT  4   consecutive port-0 grants while port 1 waits before port 1 is forced in; legal range >=1
// PORTS
//  clk                    in   1       single clock, rising edge
//  rst                    in   1       asynchronous, active-high reset
//  reqN_valid             in   1       N=0,1: request present; must hold stable until reqN_ready
//  reqN_write             in   1       1=write, 0=read
//  reqN_addr              in   ADDR_W  virtual byte address
//  reqN_wdata             in   DATA_W  write data
//  reqN_ready             out  1       request accepted this cycle (valid & ready = handshake)
//  reqN_rvalid            out  1       one-cycle completion pulse (reads and writes)
//  reqN_rdata             out  DATA_W  read data, qualified by rvalid
//  reqN_err               out  1       address error, qualified by rvalid
//  mem_bus_read           out  1       read strobe to decoder/memories
//  mem_bus_write          out  1       write strobe
//  mem_bus_rd_addr        out  ADDR_W  read address
//  mem_bus_wr_addr        out  ADDR_W  write address
//  mem_bus_wr_data        out  DATA_W  write data
//  mem_bus_rd_data        in   DATA_W  returned read data
//  mem_bus_rd_addr_error  in   1       combinational decoder error, valid while mem_bus_read=1
//  mem_bus_wr_addr_error  in   1       combinational decoder error, valid while mem_bus_write=1
//  busy                   out  1       state != IDLE
// BEHAVIOUR
//  Reset
//   - State goes to IDLE; every output, latch and counter resets to 0. Applies asynchronously, mid-transaction included.
//   - An in-flight transaction is dropped: no rvalid, no strobe after reset.
//  FSM: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE
//  IDLE
//   - Any reqN_valid triggers arbitration.
//   - Winner's reqN_ready=1 combinationally in the same cycle; write flag, addr, wdata and owner id are latched.
//   - Next state is ISSUE. Loser's ready stays 0.
//  Arbitration
//   - Port 0 wins ties, except when starve_cnt==STARVE_LIMIT; then port 1 wins.
//   - starve_cnt increments on a port-0 grant while req1_valid=1.
//   - starve_cnt clears on a port-1 grant, and on any grant taken with req1_valid=0. It saturates at STARVE_LIMIT.
//  ISSUE (exactly 1 cycle)
//   - Asserts mem_bus_write or mem_bus_read; the other strobe stays 0.
//   - Samples the matching decoder error into err_q.
//   - Write: next state DONE. Read: cnt=RD_LATENCY-1; if cnt==0 next is DONE (capture data at ISSUE+1), else WAIT.
//  WAIT
//   - Decrements cnt. At cnt==0, captures mem_bus_rd_data and goes to DONE.
//  DONE (1 cycle)
//   - Owner's rvalid=1 and err=err_q. rdata = err_q ? 0 : captured data. Next state IDLE.
//   - No back-to-back accept in DONE: the next accept happens in IDLE.
//  Address and data hold
//   - mem_bus_rd/wr_addr and wr_data hold the latched request value from ISSUE until the next accept; outside that they are don't-care, qualified by the strobes.
//  Latency
//   - Write: accept->rvalid = 2 cycles.
//   - Read: accept->rvalid = RD_LATENCY+1 cycles (with the rdata capture at ISSUE+RD_LATENCY, as above).
//   - Throughput: one transaction per (latency+1) cycles.
//  Invariants
//   - The non-owner never sees ready or rvalid.
//   - Strobes are never both 1.
//   - reqN_valid dropping before ready is a protocol violation; the bench asserts it.
// STRUCTURE
//  - mips_pkg gains: typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_e; localparam ARB_STARVE_LIMIT=4; localparam ARB_RD_LATENCY=1.
//  - Sub-module mips_mem_arb_pick: combinational winner select plus the registered starve counter.
//  - Everything else (FSM, latches, latency counter) lives in the top.
// TESTING
//  1. Reset mid-read (assert rst during WAIT) -> strobes 0 next edge, no rvalid, busy=0, starve_cnt=0.
//  2. req0 write 0x10010004 data 0xDEADBEEF -> ready0 in cycle 0, mem_bus_write=1 in cycle 1 with that addr/data, rvalid0=1 err0=0 in cycle 2.
//  3. req1 read 0x7FFFEFFC, RD_LATENCY=3, memory returns 0x12345678 -> mem_bus_read=1 for 1 cycle, rvalid1 4 cycles after accept, rdata1=0x12345678.
//  4. req0 read 0x00000010, decoder raises rd error -> rvalid0=1, err0=1, rdata0=0; the next request proceeds normally.
//  5. Both valid continuously with STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1...
//  6. req1 alone -> granted immediately; starve_cnt stays 0; no ready0/rvalid0 ever.

Source files
------------

// File: rtl/mips_mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_bus_arbiter_pkg
//   Shared types and defaults for the data-memory bus arbiter.
//   - arb_state_e      : arbiter FSM states
//   - ARB_*            : default bus widths, read latency and starvation limit
//   - ARB_CNT_W        : width of the read-latency down-counter (latency 1..7)
// ---------------------------------------------------------------------------
package mips_mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  localparam int ARB_DATA_W       = 32;
  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_RD_LATENCY   = 1;
  localparam int ARB_STARVE_LIMIT = 4;

  // Read latency is at most 7, so the remaining-cycles counter fits in 3 bits.
  localparam int ARB_CNT_W        = 3;

endpackage : mips_mem_bus_arbiter_pkg

// File: rtl/mips_mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_mem_bus_arbiter_if
//   Bundles the two requester handshakes and the memory-map decoder bus.
//   Port 0 = core load/store unit, port 1 = program loader / debug master.
//   modport slave  : the arbiter's view (accepts requests, drives the bus)
//   modport master : the environment's view (requesters + decoder/memories)
// ---------------------------------------------------------------------------
interface mips_mem_bus_arbiter_if
  import mips_mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int ADDR_W = ARB_ADDR_W
) ();

  // Requester 0
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  // Requester 1
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  // Memory-map decoder bus
  logic              mem_bus_read;
  logic              mem_bus_write;
  logic [ADDR_W-1:0] mem_bus_rd_addr;
  logic [ADDR_W-1:0] mem_bus_wr_addr;
  logic [DATA_W-1:0] mem_bus_wr_data;
  logic [DATA_W-1:0] mem_bus_rd_data;
  logic              mem_bus_rd_addr_error;
  logic              mem_bus_wr_addr_error;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata, req1_err,
    output mem_bus_read, mem_bus_write,
    output mem_bus_rd_addr, mem_bus_wr_addr, mem_bus_wr_data,
    input  mem_bus_rd_data, mem_bus_rd_addr_error, mem_bus_wr_addr_error
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata, req1_err,
    input  mem_bus_read, mem_bus_write,
    input  mem_bus_rd_addr, mem_bus_wr_addr, mem_bus_wr_data,
    output mem_bus_rd_data, mem_bus_rd_addr_error, mem_bus_wr_addr_error
  );

endinterface : mips_mem_bus_arbiter_if

// File: rtl/mips_mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mips_mem_arb_pick
//   Winner select for the two-port arbiter plus the starvation counter.
//   Port 0 wins ties until port 1 has watched STARVE_LIMIT consecutive
//   port-0 grants; then port 1 is forced in.
//   clk, rst     : clock, asynchronous active-high reset
//   req0_valid   : port 0 requesting
//   req1_valid   : port 1 requesting
//   accept       : a grant is being taken this cycle (arbiter idle, any valid)
//   grant1       : 1 = port 1 wins, 0 = port 0 wins (meaningful with accept)
// ---------------------------------------------------------------------------
module mips_mem_arb_pick
  import mips_mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic accept,
  output logic grant1
);

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant1 = req1_valid && (!req0_valid || (starve_cnt_q == LIMIT));
  end

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    starve_cnt_d = starve_cnt_q;
    if (accept) begin
      if (!grant1 && req1_valid) begin
        // Port 0 took the bus while port 1 was waiting.
        if (starve_cnt_q != LIMIT) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end else begin
        // Port 1 got in, or nobody was waiting behind port 0.
        starve_cnt_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule : mips_mem_arb_pick

// File: rtl/mips_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_bus_arbiter
//   Shares the single data-memory bus between the core load/store unit
//   (port 0) and the program loader / debug master (port 1). One transaction
//   at a time: IDLE (accept) -> ISSUE (strobe) -> WAIT (read latency) -> DONE
//   (completion pulse) -> IDLE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshakes and decoder bus (slave modport)
//   busy     : arbiter is not idle
// ---------------------------------------------------------------------------
module mips_mem_bus_arbiter
  import mips_mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W       = ARB_DATA_W,
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int RD_LATENCY   = ARB_RD_LATENCY,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_mem_bus_arbiter_if.slave  bus,
  output logic                   busy
);

  // Cycles still to wait after ISSUE before read data is on the bus.
  localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(RD_LATENCY - 1);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;   // 0 = port 0, 1 = port 1
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      addr_q,  addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   err_q,   err_d;
  logic [ARB_CNT_W-1:0]   cnt_q,   cnt_d;

  logic                   accept;
  logic                   grant1;
  logic                   done_pulse;
  logic [DATA_W-1:0]      done_rdata;

  mips_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .accept     (accept),
    .grant1     (grant1)
  );

  // -------------------------------------------------------------------------
  // Next state, request latches and bus strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    write_d           = write_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    err_d             = err_q;
    cnt_d             = cnt_q;
    accept            = 1'b0;
    bus.req0_ready    = 1'b0;
    bus.req1_ready    = 1'b0;
    bus.mem_bus_read  = 1'b0;
    bus.mem_bus_write = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept  = 1'b1;
          owner_d = grant1;
          state_d = ARB_ISSUE;
          if (grant1) begin
            bus.req1_ready = 1'b1;
            write_d        = bus.req1_write;
            addr_d         = bus.req1_addr;
            wdata_d        = bus.req1_wdata;
          end else begin
            bus.req0_ready = 1'b1;
            write_d        = bus.req0_write;
            addr_d         = bus.req0_addr;
            wdata_d        = bus.req0_wdata;
          end
        end
      end

      ARB_ISSUE: begin
        // The decoder error is combinational and only valid under its strobe,
        // so it is sampled here, the one cycle the strobe is high.
        if (write_q) begin
          bus.mem_bus_write = 1'b1;
          err_d             = bus.mem_bus_wr_addr_error;
          state_d           = ARB_DONE;
        end else begin
          bus.mem_bus_read  = 1'b1;
          err_d             = bus.mem_bus_rd_addr_error;
          cnt_d             = CNT_LOAD;
          state_d           = (CNT_LOAD == '0) ? ARB_DONE : ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = ARB_DONE;
        end
      end

      ARB_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Completion. DONE is the cycle ISSUE+RD_LATENCY in which read data is
  // valid; the address is still held, so the data is taken straight off the
  // bus and qualified by rvalid. Errored reads and writes return zero.
  // -------------------------------------------------------------------------
  always_comb begin
    done_pulse = (state_q == ARB_DONE);
    done_rdata = (err_q || write_q) ? '0 : bus.mem_bus_rd_data;

    bus.req0_rvalid = done_pulse && !owner_q;
    bus.req0_err    = done_pulse && !owner_q && err_q;
    bus.req0_rdata  = (done_pulse && !owner_q) ? done_rdata : '0;

    bus.req1_rvalid = done_pulse && owner_q;
    bus.req1_err    = done_pulse && owner_q && err_q;
    bus.req1_rdata  = (done_pulse && owner_q) ? done_rdata : '0;
  end

  // Addresses and write data hold the latched request until the next accept;
  // the strobes say when they mean anything.
  always_comb begin
    bus.mem_bus_rd_addr = addr_q;
    bus.mem_bus_wr_addr = addr_q;
    bus.mem_bus_wr_data = wdata_q;
    busy                = (state_q != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : mips_mem_bus_arbiter

// File: tb/tb_mips_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_bus_arbiter
//   Directed bench for the data-memory bus arbiter. dut runs with a read
//   latency of 3, dut_b with the default latency of 1. The decoder model
//   flags addresses below 0x00400000 or with bit 31 set; read data comes
//   from mem_rdata, set per transaction.
// ---------------------------------------------------------------------------
module tb_mips_mem_bus_arbiter;

  typedef struct {
    bit          port;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  logic [31:0] mem_rdata;

  int checks     = 0;
  int failures   = 0;
  int proto_err  = 0;

  always #5 clk = ~clk;

  mips_mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  mips_mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

  mips_mem_bus_arbiter #(
    .DATA_W(32), .ADDR_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a),
    .busy (busy_a)
  );

  mips_mem_bus_arbiter #(
    .DATA_W(32), .ADDR_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b),
    .busy (busy_b)
  );

  // Decoder / memory model
  function automatic logic bad_addr(input logic [31:0] a);
    return a[31] || (a < 32'h0040_0000);
  endfunction

  assign bus_a.mem_bus_rd_data       = mem_rdata;
  assign bus_a.mem_bus_rd_addr_error = bus_a.mem_bus_read  && bad_addr(bus_a.mem_bus_rd_addr);
  assign bus_a.mem_bus_wr_addr_error = bus_a.mem_bus_write && bad_addr(bus_a.mem_bus_wr_addr);
  assign bus_b.mem_bus_rd_data       = mem_rdata;
  assign bus_b.mem_bus_rd_addr_error = bus_b.mem_bus_read  && bad_addr(bus_b.mem_bus_rd_addr);
  assign bus_b.mem_bus_wr_addr_error = bus_b.mem_bus_write && bad_addr(bus_b.mem_bus_wr_addr);

  // Protocol monitor: valid must hold until ready; strobes never both high.
  logic pend0_a, pend1_a, pend0_b;
  always @(posedge clk) begin
    if (rst) begin
      pend0_a <= 1'b0;
      pend1_a <= 1'b0;
      pend0_b <= 1'b0;
    end else begin
      if ((pend0_a && !bus_a.req0_valid) || (pend1_a && !bus_a.req1_valid) ||
          (pend0_b && !bus_b.req0_valid))
        $display("protocol violation: valid dropped before ready at %0t", $time);
      if ((bus_a.mem_bus_read && bus_a.mem_bus_write) ||
          (bus_b.mem_bus_read && bus_b.mem_bus_write))
        $display("protocol violation: both strobes high at %0t", $time);
      proto_err <= proto_err
                 + int'(pend0_a && !bus_a.req0_valid)
                 + int'(pend1_a && !bus_a.req1_valid)
                 + int'(pend0_b && !bus_b.req0_valid)
                 + int'(bus_a.mem_bus_read && bus_a.mem_bus_write)
                 + int'(bus_b.mem_bus_read && bus_b.mem_bus_write);
      pend0_a <= bus_a.req0_valid && !bus_a.req0_ready;
      pend1_a <= bus_a.req1_valid && !bus_a.req1_ready;
      pend0_b <= bus_b.req0_valid && !bus_b.req0_ready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      bus_a.req1_valid = v; bus_a.req1_write = w; bus_a.req1_addr = a; bus_a.req1_wdata = d;
    end else begin
      bus_a.req0_valid = v; bus_a.req0_write = w; bus_a.req0_addr = a; bus_a.req0_wdata = d;
    end
  endtask

  function automatic logic rdy_a(input bit p);
    return p ? bus_a.req1_ready : bus_a.req0_ready;
  endfunction
  function automatic logic rv_a(input bit p);
    return p ? bus_a.req1_rvalid : bus_a.req0_rvalid;
  endfunction
  function automatic logic err_a(input bit p);
    return p ? bus_a.req1_err : bus_a.req0_err;
  endfunction
  function automatic logic [31:0] rdata_a(input bit p);
    return p ? bus_a.req1_rdata : bus_a.req0_rdata;
  endfunction

  // One transaction on dut: accept, ISSUE contents, latency, completion.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, strobes, stray;
    bit done;
    @(posedge clk); #1;
    mem_rdata = v.mem;
    drive(v.port, 1'b1, v.write, v.addr, v.wdata);
    @(negedge clk);
    check($sformatf("v%0d_ready_own", idx), 32'(rdy_a(v.port)), 32'd1);
    check($sformatf("v%0d_ready_other", idx), 32'(rdy_a(!v.port)), 32'd0);
    lat = 0; strobes = 0; stray = 0; done = 1'b0;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      if (lat == 0) drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      lat++;
      if (bus_a.mem_bus_read || bus_a.mem_bus_write) strobes++;
      if (rdy_a(1'b0) || rdy_a(1'b1) || rv_a(!v.port)) stray++;
      if (lat == 1) begin
        check($sformatf("v%0d_wr_strobe", idx), 32'(bus_a.mem_bus_write), 32'(v.write));
        check($sformatf("v%0d_rd_strobe", idx), 32'(bus_a.mem_bus_read), 32'(!v.write));
        if (v.write) begin
          check($sformatf("v%0d_wr_addr", idx), bus_a.mem_bus_wr_addr, v.addr);
          check($sformatf("v%0d_wr_data", idx), bus_a.mem_bus_wr_data, v.wdata);
        end else begin
          check($sformatf("v%0d_rd_addr", idx), bus_a.mem_bus_rd_addr, v.addr);
        end
      end
      if (rv_a(v.port)) done = 1'b1;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_err", idx), 32'(err_a(v.port)), 32'(v.exp_err));
    if (!v.write) check($sformatf("v%0d_rdata", idx), rdata_a(v.port), v.exp_rdata);
    check($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'd1);
    check($sformatf("v%0d_non_owner_events", idx), 32'(stray), 32'd0);
  endtask

  // One read on dut_b (latency 1): accept at 0, strobe at 1, rvalid at 2.
  task automatic b_read(input logic [31:0] a, input logic [31:0] m, input bit e,
                        input logic [31:0] exp_d, input string tag);
    @(posedge clk); #1;
    mem_rdata = m;
    bus_b.req0_valid = 1'b1; bus_b.req0_write = 1'b0; bus_b.req0_addr = a;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus_b.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus_b.req0_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rd_strobe"}, 32'(bus_b.mem_bus_read), 32'd1);
    check({tag, "_rvalid_early"}, 32'(bus_b.req0_rvalid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(bus_b.req0_rvalid), 32'd1);
    check({tag, "_err"}, 32'(bus_b.req0_err), 32'(e));
    check({tag, "_rdata"}, bus_b.req0_rdata, exp_d);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, bus_b.req0_rvalid, busy_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    bit   exp_g[10];
    int   got[10];
    int   n, cyc, stray;
    bit   found;

    vecs[0] = '{1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 2, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h7FFF_EFFC, 32'h0,         32'h1234_5678, 4, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h5555_5555, 4, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         32'hA5A5_0F0F, 4, 1'b0, 32'hA5A5_0F0F};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0001, 32'h0,         2, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, 32'h0,         2, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         32'h1111_1111, 4, 1'b1, 32'h0};
    exp_g   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // ---- reset state ------------------------------------------------------
    rst = 1'b1;
    mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus_b.req0_valid = 1'b0; bus_b.req0_write = 1'b0; bus_b.req0_addr = 32'h0; bus_b.req0_wdata = 32'h0;
    bus_b.req1_valid = 1'b0; bus_b.req1_write = 1'b0; bus_b.req1_addr = 32'h0; bus_b.req1_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_strobes", {30'd0, bus_a.mem_bus_read, bus_a.mem_bus_write}, 32'd0);
    check("rst_rvalid", {30'd0, bus_a.req0_rvalid, bus_a.req1_rvalid}, 32'd0);
    check("rst_starve", 32'(dut.u_pick.starve_cnt_q), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- single transactions ----------------------------------------------
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    check("starve_after_solo", 32'(dut.u_pick.starve_cnt_q), 32'd0);

    // ---- both ports valid continuously: starvation forcing ----------------
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h1001_0100, 32'h0000_00A0);
    drive(1'b1, 1'b1, 1'b1, 32'h1001_0200, 32'h0000_00B1);
    for (int i = 0; i < 10; i++) got[i] = 9;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus_a.req0_ready && !bus_a.req1_ready) begin got[n] = 0; n++; end
      else if (bus_a.req1_ready && !bus_a.req0_ready) begin got[n] = 1; n++; end
      else if (bus_a.req0_ready && bus_a.req1_ready) begin got[n] = 2; n++; end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) check($sformatf("t5_grant%0d", i), 32'(got[i]), 32'(exp_g[i]));
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_a.req0_ready) found = 1'b1;
      @(posedge clk); #1;
    end
    check("t5_port0_drained", 32'(found), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // ---- asynchronous reset in the middle of a read -----------------------
    mem_rdata = 32'h0BAD_0BAD;
    drive(1'b0, 1'b1, 1'b0, 32'h1001_0040, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h1001_0044, 32'h0000_0077);
    @(negedge clk);
    check("rstmid_ready0", 32'(bus_a.req0_ready), 32'd1);
    check("rstmid_ready1", 32'(bus_a.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rstmid_issue_read", 32'(bus_a.mem_bus_read), 32'd1);
    check("rstmid_starve_before", 32'(dut.u_pick.starve_cnt_q), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_busy_wait", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rstmid_busy", 32'(busy_a), 32'd0);
    check("rstmid_strobes", {30'd0, bus_a.mem_bus_read, bus_a.mem_bus_write}, 32'd0);
    check("rstmid_starve", 32'(dut.u_pick.starve_cnt_q), 32'd0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_a.req0_rvalid || bus_a.req1_rvalid || bus_a.mem_bus_read ||
          bus_a.mem_bus_write || busy_a) stray++;
      @(posedge clk); #1;
      if (i == 1) rst = 1'b0;
    end
    check("rstmid_no_completion", 32'(stray), 32'd0);

    // ---- read latency 1 on dut_b -------------------------------------------
    b_read(32'h1001_0020, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, "b_read_ok");
    b_read(32'h0000_0100, 32'h7777_7777, 1'b1, 32'h0000_0000, "b_read_err");

    check("protocol_violations", 32'(proto_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_mem_bus_arbiter
